// File: rtl/switch_instr_loader.sv
// rtl/switch_instr_loader.sv - debounced switch-to-instruction-memory loader with CPU hold
// Optional last_word display register is built only when LOADER_LAST_WORD_EN is defined.
module switch_instr_loader #(
  parameter int DATA_W          = 16,
  parameter int ADDR_W          = 5,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_mode,
  input  logic              key_load_n,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              mem_ready,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              cpu_hold
`ifdef LOADER_LAST_WORD_EN
  ,
  output logic [DATA_W-1:0] last_word
`endif
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W:0] WORDS   = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PRESS,
    S_DB_PRESS,
    S_WRITE,
    S_DB_RELEASE,
    S_FULL
  } state_t;

  state_t          state;
  logic [DB_W-1:0] db_cnt;
  logic            key_meta;
  logic            key_s;
  logic            mode_meta;
  logic            mode_s;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      count     <= '0;
      full      <= 1'b0;
      cpu_hold  <= 1'b0;
      db_cnt    <= '0;
      key_meta  <= 1'b1;
      key_s     <= 1'b1;
      mode_meta <= 1'b0;
      mode_s    <= 1'b0;
    end else begin
      key_meta  <= key_load_n;
      key_s     <= key_meta;
      mode_meta <= load_mode;
      mode_s    <= mode_meta;

      case (state)
        S_IDLE: begin
          // count, mem_addr and full stay readable here until loading restarts
          if (mode_s) begin
            state    <= S_WAIT_PRESS;
            mem_addr <= '0;
            count    <= '0;
            full     <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end

        S_WAIT_PRESS: begin
          if (!mode_s) begin
            state    <= S_IDLE;
            cpu_hold <= 1'b0;
          end else if (!key_s) begin
            state  <= S_DB_PRESS;
            db_cnt <= '0;
          end
        end

        S_DB_PRESS: begin
          if (!mode_s) begin
            state    <= S_IDLE;
            cpu_hold <= 1'b0;
          end else if (key_s) begin
            state <= S_WAIT_PRESS;
          end else if (db_cnt == DB_LAST) begin
            mem_data <= sw_data;
            mem_wr   <= 1'b1;
            state    <= S_WRITE;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        S_WRITE: begin
          // A started write always completes, even if loading was switched off meanwhile
          if (mem_ready) begin
            mem_wr   <= 1'b0;
            count    <= count + 1'b1;
            mem_addr <= mem_addr + 1'b1;
            db_cnt   <= '0;
            if (mode_s) begin
              state <= S_DB_RELEASE;
            end else begin
              state    <= S_IDLE;
              cpu_hold <= 1'b0;
            end
          end
        end

        S_DB_RELEASE: begin
          if (!mode_s) begin
            state    <= S_IDLE;
            cpu_hold <= 1'b0;
          end else if (!key_s) begin
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            if (count == WORDS) begin
              full  <= 1'b1;
              state <= S_FULL;
            end else begin
              state <= S_WAIT_PRESS;
            end
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end

        S_FULL: begin
          if (!mode_s) begin
            state    <= S_IDLE;
            cpu_hold <= 1'b0;
          end
        end

        default: begin
          state    <= S_IDLE;
          mem_wr   <= 1'b0;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

`ifdef LOADER_LAST_WORD_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_word <= '0;
    end else if (mem_wr && mem_ready) begin
      last_word <= mem_data;
    end
  end
`else
  // Build without the last-word display register.
`endif

endmodule
